// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the CPU run monitor: run-control states,
// default halt opcode and a width helper for address/counter sizing.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DUMP_RF,
        DUMP_DM,
        DONE
    } run_state_t;

    localparam logic [15:0] DEFAULT_HALT_PATTERN = 16'hFFFF;

    // Never returns 0 so that single-entry ranges still get a 1-bit field.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Valid/ready state-dump stream from the run monitor to its consumer.
interface cpu_run_monitor_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);

    logic              dump_valid_o;
    logic              dump_ready_i;
    logic              dump_is_mem_o;
    logic [IDX_W-1:0]  dump_idx_o;
    logic [DATA_W-1:0] dump_data_o;

    modport master (
        output dump_valid_o,
        output dump_is_mem_o,
        output dump_idx_o,
        output dump_data_o,
        input  dump_ready_i
    );

    modport slave (
        input  dump_valid_o,
        input  dump_is_mem_o,
        input  dump_idx_o,
        input  dump_data_o,
        output dump_ready_i
    );

endinterface

// File: rtl/dump_sequencer.sv
// Walks the register file then data memory through spare async read ports and
// presents each word on a registered valid/ready stream, one word per cycle.
module dump_sequencer #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 8,
    parameter int MEM_WORDS = 32,
    parameter int IDX_W     = 5,
    parameter int RA_W      = 3,
    parameter int DA_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              dump_rf,
    input  logic              dump_dm,
    output logic [RA_W-1:0]   rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [DA_W-1:0]   dm_raddr_o,
    input  logic [DATA_W-1:0] dm_rdata_i,
    output logic              phase_done,
    cpu_run_monitor_if.master dump
);

    localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(MEM_WORDS - 1);

    logic [IDX_W-1:0]  idx_q;
    logic              exhausted_q;
    logic              valid_q;
    logic              is_mem_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [DATA_W-1:0] data_q;

    logic              active;
    logic              accept;
    logic              load;
    logic [IDX_W-1:0]  last_idx;

    assign active   = dump_rf || dump_dm;
    assign accept   = valid_q && dump.dump_ready_i;
    assign last_idx = dump_dm ? DM_LAST : RF_LAST;
    // A new word may be fetched whenever the output slot is empty or draining this cycle.
    assign load     = active && !exhausted_q && (!valid_q || dump.dump_ready_i);

    // exhausted_q marks that the phase's last word is in the output slot; its acceptance ends the phase.
    assign phase_done = accept && exhausted_q;

    assign rf_raddr_o = idx_q[RA_W-1:0];
    assign dm_raddr_o = idx_q[DA_W-1:0];

    assign dump.dump_valid_o  = valid_q;
    assign dump.dump_is_mem_o = is_mem_q;
    assign dump.dump_idx_o    = out_idx_q;
    assign dump.dump_data_o   = data_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            exhausted_q <= 1'b0;
            valid_q     <= 1'b0;
            is_mem_q    <= 1'b0;
            out_idx_q   <= '0;
            data_q      <= '0;
        end else if (load) begin
            valid_q   <= 1'b1;
            is_mem_q  <= dump_dm;
            out_idx_q <= idx_q;
            data_q    <= dump_dm ? dm_rdata_i : rf_rdata_i;
            if (idx_q == last_idx) begin
                idx_q       <= '0;
                exhausted_q <= 1'b1;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else if (accept) begin
            valid_q     <= 1'b0;
            exhausted_q <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control and state-dump monitor for the single-cycle CPU.
// Define RUN_MONITOR_CHECKSUM_EN to add checksum_o, the sum of all accepted dump words.
module cpu_run_monitor
    import run_monitor_pkg::*;
#(
    parameter int                 INSTR_W      = 16,
    parameter int                 DATA_W       = 16,
    parameter int                 NUM_REGS     = 8,
    parameter int                 MEM_WORDS    = 32,
    parameter int                 MAX_CYCLES   = 50,
    parameter int                 DRAIN_CYCLES = 2,
    parameter logic [INSTR_W-1:0] HALT_PATTERN = INSTR_W'(DEFAULT_HALT_PATTERN)
) (
    input  logic                                clk_i,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic                                instr_valid_i,
    input  logic [INSTR_W-1:0]                  instr_i,
    output logic [clog2(NUM_REGS)-1:0]          rf_raddr_o,
    input  logic [DATA_W-1:0]                   rf_rdata_i,
    output logic [clog2(MEM_WORDS)-1:0]         dm_raddr_o,
    input  logic [DATA_W-1:0]                   dm_rdata_i,
    cpu_run_monitor_if.master                   dump,
    output logic [clog2(MAX_CYCLES+1)-1:0]      cycle_count_o,
    output logic                                halted_o,
    output logic                                timeout_o,
    output logic                                done_o
`ifdef RUN_MONITOR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]                   checksum_o
`endif
);

    localparam int RA_W  = clog2(NUM_REGS);
    localparam int DA_W  = clog2(MEM_WORDS);
    localparam int IDX_W = clog2((NUM_REGS > MEM_WORDS) ? NUM_REGS : MEM_WORDS);
    localparam int CNT_W = clog2(MAX_CYCLES + 1);
    localparam int DRN_W = clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_CYCLES);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam run_state_t       AFTER_RUN  = (DRAIN_CYCLES == 0) ? DUMP_RF : DRAIN;

    run_state_t       state_q, state_d;
    logic [DRN_W-1:0] drain_q;
    logic             clear_run, count_inc, set_halt, set_timeout, set_done;
    logic             drain_clr, drain_inc;
    logic             phase_done;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt is checked before the count so a halt on the limit cycle reports halted, not timeout.
    always_comb begin
        state_d     = state_q;
        clear_run   = 1'b0;
        count_inc   = 1'b0;
        set_halt    = 1'b0;
        set_timeout = 1'b0;
        set_done    = 1'b0;
        drain_clr   = 1'b0;
        drain_inc   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RUN;
                    clear_run = 1'b1;
                end
            end
            RUN: begin
                if (instr_valid_i) begin
                    if (instr_i == HALT_PATTERN) begin
                        set_halt  = 1'b1;
                        drain_clr = 1'b1;
                        state_d   = AFTER_RUN;
                    end else begin
                        count_inc = 1'b1;
                        if (cycle_count_o == CNT_LAST) begin
                            set_timeout = 1'b1;
                            drain_clr   = 1'b1;
                            state_d     = AFTER_RUN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = DUMP_RF;
                end else begin
                    drain_inc = 1'b1;
                end
            end
            DUMP_RF: begin
                if (phase_done) begin
                    state_d = DUMP_DM;
                end
            end
            DUMP_DM: begin
                if (phase_done) begin
                    state_d  = DONE;
                    set_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_o <= '0;
            halted_o      <= 1'b0;
            timeout_o     <= 1'b0;
            done_o        <= 1'b0;
            drain_q       <= '0;
        end else begin
            if (clear_run) begin
                cycle_count_o <= '0;
                halted_o      <= 1'b0;
                timeout_o     <= 1'b0;
                done_o        <= 1'b0;
            end else begin
                if (count_inc && (cycle_count_o != CNT_MAX)) begin
                    cycle_count_o <= cycle_count_o + CNT_W'(1);
                end
                if (set_halt) begin
                    halted_o <= 1'b1;
                end
                if (set_timeout) begin
                    timeout_o <= 1'b1;
                end
                if (set_done) begin
                    done_o <= 1'b1;
                end
            end
            if (drain_clr) begin
                drain_q <= '0;
            end else if (drain_inc) begin
                drain_q <= drain_q + DRN_W'(1);
            end
        end
    end

    dump_sequencer #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W),
        .RA_W      (RA_W),
        .DA_W      (DA_W)
    ) u_dump_sequencer (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .dump_rf    (state_q == DUMP_RF),
        .dump_dm    (state_q == DUMP_DM),
        .rf_raddr_o (rf_raddr_o),
        .rf_rdata_i (rf_rdata_i),
        .dm_raddr_o (dm_raddr_o),
        .dm_rdata_i (dm_rdata_i),
        .phase_done (phase_done),
        .dump       (dump)
    );

`ifdef RUN_MONITOR_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            checksum_o <= '0;
        end else if (clear_run) begin
            checksum_o <= '0;
        end else if (dump.dump_valid_o && dump.dump_ready_i) begin
            checksum_o <= checksum_o + dump.dump_data_o;
        end
    end
`endif

endmodule
